// File: rtl/rename_reg_file_param.sv
// Renaming register file: busy/valid/data per rename tag, lowest-free allocation,
// writeback, two read ports, commit release and flush. Optional macro RRF_WB_BYPASS_EN.
module rename_reg_file_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              wb_en_i,
    input  logic [TAG_W-1:0]  wb_tag_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [TAG_W-1:0]  rd_tag1_i,
    input  logic [TAG_W-1:0]  rd_tag2_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,
    output logic              rd_valid1_o,
    output logic              rd_valid2_o,
    input  logic              rel_en_i,
    input  logic [TAG_W-1:0]  rel_tag_i,
    input  logic              flush_i,
    output logic [TAG_W:0]    free_count_o,
    output logic              full_o
);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W:0]    free_cnt_q, free_cnt_d;

    logic              alloc_gnt_s;
    logic [TAG_W-1:0]  alloc_tag_s;
    logic              wb_hit_s;
    logic              rel_hit_s;

    assign wb_hit_s  = wb_en_i & busy_q[wb_tag_i];
    assign rel_hit_s = rel_en_i & busy_q[rel_tag_i];

    // Lowest free index: scan downward so the smallest non-busy index is kept.
    always_comb begin
        alloc_tag_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            alloc_tag_s = busy_q[i] ? alloc_tag_s : TAG_W'(i);
        end
    end

    // Grant is suppressed by flush and while reset is asserted.
    assign alloc_gnt_s  = alloc_req_i & ~full_o & ~flush_i & rst_ni;
    assign alloc_gnt_o  = alloc_gnt_s;
    assign alloc_tag_o  = alloc_tag_s;
    assign full_o       = (free_cnt_q == '0);
    assign free_count_o = free_cnt_q;

    // Next-state busy/valid: release is applied last so it wins over writeback.
    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        if (flush_i) begin
            busy_d  = '0;
            valid_d = '0;
        end else begin
            if (alloc_gnt_s) begin
                busy_d[alloc_tag_s]  = 1'b1;
                valid_d[alloc_tag_s] = 1'b0;
            end else begin
                busy_d[alloc_tag_s]  = busy_d[alloc_tag_s];
            end
            if (wb_hit_s) begin
                valid_d[wb_tag_i] = 1'b1;
            end else begin
                valid_d[wb_tag_i] = valid_d[wb_tag_i];
            end
            if (rel_hit_s) begin
                busy_d[rel_tag_i]  = 1'b0;
                valid_d[rel_tag_i] = 1'b0;
            end else begin
                busy_d[rel_tag_i]  = busy_d[rel_tag_i];
            end
        end
    end

    // Free-count next state; grant and counted release never target the same entry.
    always_comb begin
        if (flush_i) begin
            free_cnt_d = (TAG_W+1)'(DEPTH);
        end else begin
            free_cnt_d = free_cnt_q + {{TAG_W{1'b0}}, rel_hit_s}
                                    - {{TAG_W{1'b0}}, alloc_gnt_s};
        end
    end

    // Status and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            valid_q    <= '0;
            free_cnt_q <= (TAG_W+1)'(DEPTH);
        end else begin
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    // Data storage; flush retains contents and blocks the writeback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (wb_hit_s && !flush_i) begin
            data_q[wb_tag_i] <= wb_data_i;
        end
    end

`ifdef RRF_WB_BYPASS_EN
    logic byp_ok_s;
    assign byp_ok_s = wb_hit_s & ~flush_i & rst_ni & ~(rel_en_i & (rel_tag_i == wb_tag_i));

    // Read ports with same-cycle writeback forwarding.
    always_comb begin
        if (byp_ok_s && (rd_tag1_i == wb_tag_i)) begin
            rd_data1_o  = wb_data_i;
            rd_valid1_o = 1'b1;
        end else begin
            rd_data1_o  = data_q[rd_tag1_i];
            rd_valid1_o = busy_q[rd_tag1_i] & valid_q[rd_tag1_i];
        end
        if (byp_ok_s && (rd_tag2_i == wb_tag_i)) begin
            rd_data2_o  = wb_data_i;
            rd_valid2_o = 1'b1;
        end else begin
            rd_data2_o  = data_q[rd_tag2_i];
            rd_valid2_o = busy_q[rd_tag2_i] & valid_q[rd_tag2_i];
        end
    end
`else
    // Read ports see registered state only.
    always_comb begin
        rd_data1_o  = data_q[rd_tag1_i];
        rd_valid1_o = busy_q[rd_tag1_i] & valid_q[rd_tag1_i];
        rd_data2_o  = data_q[rd_tag2_i];
        rd_valid2_o = busy_q[rd_tag2_i] & valid_q[rd_tag2_i];
    end
`endif

endmodule

// File: doc/rename_reg_file_param.md
Name: rename_reg_file_param

Overview:
- Parametrised renaming register file (RRF) for the superscalar core.
- Holds speculative results indexed by rename tag, with a per-entry busy bit (allocated) and valid bit (result written).
- Allocation is lowest-index-free, with writeback from the execution units, two operand read ports, a release port driven by commit, and a flush port.
- Sits between the rename/dispatch stage and the reservation stations / ROB.

Parameters:
- DATA_W, 32, width of each entry's data.
- DEPTH, 16, number of rename entries (power of two, 4..64).
- TAG_W, $clog2(DEPTH), tag width (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- ALLOC_REQ  input  1  request one new rename entry this cycle.
- ALLOC_GNT  output  1  allocation granted (a free entry exists).
- ALLOC_TAG  output  TAG_W  tag of the granted entry.
- WB_EN  input  1  writeback strobe.
- WB_TAG  input  TAG_W  writeback target entry.
- WB_DATA  input  DATA_W  writeback value.
- RD_TAG1, RD_TAG2  input  TAG_W  read tags.
- RD_DATA1, RD_DATA2  output  DATA_W  entry data.
- RD_VALID1, RD_VALID2  output  1  entry is busy and its result is written.
- REL_EN  input  1  release strobe from commit.
- REL_TAG  input  TAG_W  entry to free.
- FLUSH  input  1  free all entries (mispredict recovery).
- FREE_COUNT  output  TAG_W+1  number of non-busy entries.
- FULL  output  1  FREE_COUNT==0.

Behaviour:
- Reset (RESETN=0, asynchronous): all busy=0, valid=0, data=0.
  - Outputs during reset: FREE_COUNT=DEPTH, FULL=0, ALLOC_GNT=0, ALLOC_TAG=0, RD_* = 0.
- ALLOC_GNT/ALLOC_TAG are combinational from registered busy bits.
  - ALLOC_TAG = lowest index with busy=0.
  - ALLOC_GNT = ALLOC_REQ & ~FULL.
  - On a grant at the clock edge: busy[tag]=1, valid[tag]=0; data is unchanged.
  - ALLOC_REQ while FULL: ALLOC_GNT=0, no state change.
- Writeback at the clock edge, only if WB_EN and busy[WB_TAG]=1:
  - data[WB_TAG]=WB_DATA, valid[WB_TAG]=1.
  - Writeback to a non-busy tag is ignored.
  - Writeback to an already valid entry overwrites the data.
- Release at the clock edge:
  - REL_EN with busy[REL_TAG]=1: busy=0, valid=0.
  - Release of a non-busy tag is ignored.
- Read ports are combinational from registered state.
  - RD_DATAn = data[RD_TAGn].
  - RD_VALIDn = busy & valid.
  - Without bypass, a writeback becomes visible one cycle after its edge.
- FLUSH (synchronous) at the clock edge: all busy=0 and valid=0.
  - Overrides alloc, writeback and release in the same cycle.
  - ALLOC_GNT is forced to 0 while FLUSH=1.
  - Data is retained.
- Simultaneous events:
  - Release and alloc in the same cycle: the released entry is not eligible for this cycle's grant (grant uses pre-edge busy).
  - Alloc and writeback to the same tag cannot collide, because the grant only targets non-busy entries, so the writeback is ignored.
  - Writeback and release to the same tag: release wins, entry ends busy=0, valid=0; data may update.
- FREE_COUNT is registered and updated each edge as count + releases − grants.
  - A release only counts if the entry was busy.
  - After FLUSH, FREE_COUNT = DEPTH.
  - FREE_COUNT never underflows or exceeds DEPTH.

Optional Feature:
- Macro RRF_WB_BYPASS_EN.
- Defined: when WB_EN and busy[WB_TAG] and RD_TAGn==WB_TAG in the same cycle, RD_DATAn=WB_DATA and RD_VALIDn=1 combinationally.
  - No bypass while FLUSH=1 or when REL_EN targets the same tag.
- Undefined: reads see registered state only (one-cycle write-to-read latency).

Test Plan:
- Reset then 16 back-to-back ALLOC_REQ (DEPTH=16) -> ALLOC_TAG 0..15 in order, then FULL=1 and FREE_COUNT=0; 17th request gives ALLOC_GNT=0.
- Alloc tag 3, WB_EN tag 3 data 0xDEADBEEF, then read RD_TAG1=3 next cycle -> RD_DATA1=0xDEADBEEF, RD_VALID1=1; on the WB cycle RD_VALID1=0 (bypass off) or 1 with 0xDEADBEEF (RRF_WB_BYPASS_EN).
- Full RRF, REL_EN tag 5 with ALLOC_REQ in the same cycle -> ALLOC_GNT=0 that cycle; next cycle ALLOC_TAG=5, ALLOC_GNT=1.
- WB_EN to non-busy tag 9 with data 0x1234 -> RD_VALID for tag 9 stays 0 and FREE_COUNT is unchanged.
- Allocate 10 entries, FLUSH together with ALLOC_REQ and WB_EN -> ALLOC_GNT=0, next cycle FREE_COUNT=16, all RD_VALID=0, next ALLOC_TAG=0.
- Assert RESETN=0 mid-operation, asynchronously off the clock edge -> all outputs return to reset values immediately and FREE_COUNT=16.
